// File: rtl/fir_pkg.sv
// Shared widths and state encoding for the parallel FIR output stage.
package fir_pkg;

    localparam int FIR_NB_IN       = 8;
    localparam int FIR_NB_COEFFS   = 8;
    localparam int FIR_N_COEFFS    = 8;
    localparam int FIR_PARALLELISM = 2;
    localparam int NB_FULL         = FIR_NB_IN + FIR_NB_COEFFS + $clog2(FIR_N_COEFFS);
    localparam int NB_OUT_DEF      = 8;
    localparam int SHIFT_DEF       = 7;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/fir_out_serializer_if.sv
// Frame-in / sample-out handshake bundle of the FIR output serializer.
// Carries o_sat only when FIR_OUT_SAT_FLAG_EN is defined.
interface fir_out_serializer_if
    import fir_pkg::*;
#(
    parameter int NB_IN       = NB_FULL,
    parameter int PARALLELISM = FIR_PARALLELISM,
    parameter int NB_OUT      = NB_OUT_DEF
);

    logic [PARALLELISM*NB_IN-1:0] i_data;
    logic                         i_valid;
    logic                         o_ready;
    logic signed [NB_OUT-1:0]     o_data;
    logic                         o_valid;
    logic                         i_ready;
`ifdef FIR_OUT_SAT_FLAG_EN
    logic                         o_sat;
`endif

    modport slave (
        input  i_data, i_valid, i_ready,
        output o_ready, o_data, o_valid
`ifdef FIR_OUT_SAT_FLAG_EN
        , output o_sat
`endif
    );

    modport master (
        output i_data, i_valid, i_ready,
        input  o_ready, o_data, o_valid
`ifdef FIR_OUT_SAT_FLAG_EN
        , input o_sat
`endif
    );

endinterface

// File: rtl/fir_out_serializer_round_sat.sv
// Round-half-up by SHIFT bits, then saturate one FIR lane to NB_OUT bits.
module fir_round_sat #(
    parameter int NB_IN  = 19,
    parameter int NB_OUT = 8,
    parameter int SHIFT  = 7
) (
    input  logic [NB_IN-1:0]         x,
    output logic signed [NB_OUT-1:0] y,
    output logic                     sat
);

    // One extra bit keeps the rounding add free of overflow
    localparam logic signed [NB_IN:0] ROUND   = {{NB_IN{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [NB_IN:0] SAT_MAX = (NB_IN+1)'((1 << (NB_OUT - 1)) - 1);
    localparam logic signed [NB_IN:0] SAT_MIN = ~SAT_MAX;

    logic signed [NB_IN:0] t_s;
    logic signed [NB_IN:0] shifted_s;

    // Rounding add, arithmetic shift and clip to the output range
    always_comb begin
        t_s       = $signed({x[NB_IN-1], x}) + ROUND;
        shifted_s = t_s >>> SHIFT;
        y         = SAT_MAX[NB_OUT-1:0];
        sat       = 1'b0;
        if (shifted_s > SAT_MAX) begin
            y   = SAT_MAX[NB_OUT-1:0];
            sat = 1'b1;
        end else if (shifted_s < SAT_MIN) begin
            y   = SAT_MIN[NB_OUT-1:0];
            sat = 1'b1;
        end else begin
            y   = shifted_s[NB_OUT-1:0];
            sat = 1'b0;
        end
    end

endmodule

// File: rtl/fir_out_serializer.sv
// Quantizes a frame of PARALLELISM FIR lanes and streams them out one per clock.
// Optional feature macro: FIR_OUT_SAT_FLAG_EN (per-sample saturation flag on o_sat).
module fir_out_serializer
    import fir_pkg::*;
#(
    parameter int NB_IN       = NB_FULL,
    parameter int PARALLELISM = FIR_PARALLELISM,
    parameter int NB_OUT      = NB_OUT_DEF,
    parameter int SHIFT       = SHIFT_DEF
) (
    input logic                  i_clock,
    input logic                  i_reset,
    fir_out_serializer_if.slave  bus
);

    localparam int                IDX_W    = $clog2(PARALLELISM);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PARALLELISM - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1'b1);

    logic signed [NB_OUT-1:0] lane_q_s [PARALLELISM];
    logic signed [NB_OUT-1:0] frame_r  [PARALLELISM];
    logic [IDX_W-1:0]         idx_r;
    logic [IDX_W-1:0]         idx_inc_s;
    logic signed [NB_OUT-1:0] o_data_r;
    logic                     o_valid_r;
    state_t                   state_r;
    state_t                   state_s;
    logic                     consume_s;
    logic                     last_s;
    logic                     ready_s;
    logic                     accept_s;

`ifdef FIR_OUT_SAT_FLAG_EN
    logic [PARALLELISM-1:0]   lane_sat_s;
    logic [PARALLELISM-1:0]   sat_frame_r;
    logic                     o_sat_r;
`else
    logic [PARALLELISM-1:0]   lane_sat_unused_s;
`endif

    for (genvar p = 0; p < PARALLELISM; p++) begin : g_lane
        fir_round_sat #(
            .NB_IN  (NB_IN),
            .NB_OUT (NB_OUT),
            .SHIFT  (SHIFT)
        ) u_round_sat (
            .x   (bus.i_data[p*NB_IN +: NB_IN]),
            .y   (lane_q_s[p]),
`ifdef FIR_OUT_SAT_FLAG_EN
            .sat (lane_sat_s[p])
`else
            .sat (lane_sat_unused_s[p])
`endif
        );
    end

    // Handshake decode: a new frame may land on the same edge the last lane leaves
    always_comb begin
        consume_s = (state_r == FULL) && bus.i_ready;
        last_s    = (idx_r == LAST_IDX);
        ready_s   = (state_r == EMPTY) || (consume_s && last_s);
        accept_s  = bus.i_valid && ready_s;
        idx_inc_s = idx_r + IDX_ONE;
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            EMPTY: begin
                if (accept_s) state_s = FULL;
                else          state_s = EMPTY;
            end
            FULL: begin
                if (consume_s && last_s && !accept_s) state_s = EMPTY;
                else                                  state_s = FULL;
            end
            default: state_s = EMPTY;
        endcase
    end

    // State, frame buffer, lane index and registered sample output
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r   <= EMPTY;
            idx_r     <= '0;
            o_data_r  <= '0;
            o_valid_r <= 1'b0;
            for (int p = 0; p < PARALLELISM; p++) frame_r[p] <= '0;
        end else begin
            state_r   <= state_s;
            o_valid_r <= (state_s == FULL);
            if (accept_s) begin
                idx_r    <= '0;
                o_data_r <= lane_q_s[0];
                for (int p = 0; p < PARALLELISM; p++) frame_r[p] <= lane_q_s[p];
            end else if (consume_s && !last_s) begin
                idx_r    <= idx_inc_s;
                o_data_r <= frame_r[idx_inc_s];
            end
        end
    end

`ifdef FIR_OUT_SAT_FLAG_EN
    // Saturation flags travel with their lanes
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            sat_frame_r <= '0;
            o_sat_r     <= 1'b0;
        end else if (accept_s) begin
            sat_frame_r <= lane_sat_s;
            o_sat_r     <= lane_sat_s[0];
        end else if (consume_s && !last_s) begin
            o_sat_r     <= sat_frame_r[idx_inc_s];
        end
    end

    assign bus.o_sat = o_sat_r;
`endif

    assign bus.o_ready = ready_s;
    assign bus.o_data  = o_data_r;
    assign bus.o_valid = o_valid_r;

endmodule
